servo_slew_scheduler: RTL and testbench

Four-channel servo frame scheduler between the joystick-to-servo mapping logic and the servo PMOD pins. It owns the common 20 ms servo frame, holds a clamped target pulse width per channel, and once per frame steps each channel's current pulse width toward its target by a bounded amount (slew limiting). From the current widths it drives all four PWM outputs.

---
 rtl/servo_pkg.sv | 32 +++
 rtl/servo_frame_timer.sv | 50 +++++
 rtl/servo_slew_scheduler.sv | 165 ++++++++++++++++
 tb/tb_servo_slew_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo frame scheduler.
// Pulse widths are carried in microseconds as unsigned US_W-bit values.
package servo_pkg;

    localparam int US_W   = 12;
    localparam int NUM_CH = 4;

    typedef logic [US_W-1:0] us_t;

    localparam us_t MIN_US    = 12'd500;
    localparam us_t MAX_US    = 12'd2500;
    localparam us_t CENTER_US = 12'd1500;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } servo_state_e;

    // Saturate a requested width into the legal servo range.
    function automatic us_t clamp_us(input us_t v);
        us_t r;
        if (v < MIN_US) begin
            r = MIN_US;
        end else if (v > MAX_US) begin
            r = MAX_US;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timebase: microsecond prescaler, in-frame microsecond counter and
// the registered frame_start strobe.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int CYC_PER_US = 25,
    parameter int FRAME_US   = 20000
) (
    input  logic                        CLK,
    input  logic                        RST,
    output logic [$clog2(FRAME_US)-1:0] us_cnt,
    output logic                        pre_zero,
    output logic                        frame_hit,
    output logic                        frame_start
);

    localparam int PRE_W    = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int US_CNT_W = $clog2(FRAME_US);

    logic [PRE_W-1:0] prescaler_r;
    logic             pre_wrap_s;
    logic             us_wrap_s;

    assign pre_wrap_s = (prescaler_r == PRE_W'(CYC_PER_US - 1));
    assign us_wrap_s  = (us_cnt == US_CNT_W'(FRAME_US - 1));
    assign pre_zero   = (prescaler_r == {PRE_W{1'b0}});
    assign frame_hit  = pre_zero && (us_cnt == {US_CNT_W{1'b0}});

    // Counter chain and frame strobe; the strobe trails the counter origin by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler_r <= {PRE_W{1'b0}};
            us_cnt      <= {US_CNT_W{1'b0}};
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_hit;
            if (pre_wrap_s) begin
                prescaler_r <= {PRE_W{1'b0}};
                if (us_wrap_s) begin
                    us_cnt <= {US_CNT_W{1'b0}};
                end else begin
                    us_cnt <= us_cnt + US_CNT_W'(1);
                end
            end else begin
                prescaler_r <= prescaler_r + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/servo_slew_scheduler.sv
// Four-channel servo frame scheduler with per-frame slew limiting.
// Build option: define SERVO_SLEW_EN for bounded steps; otherwise the sweep copies target to current.
module servo_slew_scheduler
    import servo_pkg::*;
#(
    parameter int CYC_PER_US = 25,
    parameter int FRAME_US   = 20000,
    parameter int UPDATE_US  = 12000,
    parameter int STEP_US    = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_ch,
    input  logic [11:0] wr_us,
    output logic [3:0]  servo_pwm,
    output logic        frame_start,
    output logic        busy
);

    localparam int US_CNT_W = $clog2(FRAME_US);
    localparam int CMP_W    = (US_CNT_W > US_W) ? US_CNT_W : US_W;

`ifdef SERVO_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // Without slew limiting the step bound exceeds any possible difference.
    localparam int  STEP_LIM = SLEW_ON ? STEP_US : (1 << US_W);
    localparam us_t STEP_U   = US_W'(STEP_US);

    localparam logic [0:0] ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] ST_UPDATE = 1'(UPDATE);

    logic [US_CNT_W-1:0] us_cnt_s;
    logic                pre_zero_s;
    logic                frame_hit_s;
    logic                update_hit_s;

    logic [0:0]          state_r;
    logic [0:0]          state_nxt_s;
    logic [1:0]          sweep_r;
    logic                en_frame_r;
    logic                en_now_s;

    us_t                 target_r  [NUM_CH];
    us_t                 current_r [NUM_CH];

    us_t                 tgt_s;
    us_t                 cur_s;
    us_t                 raw_s;
    us_t                 cur_nxt_s;
    logic signed [US_W:0] diff_s;
    logic [NUM_CH-1:0]   pwm_nxt_s;

    servo_frame_timer #(
        .CYC_PER_US (CYC_PER_US),
        .FRAME_US   (FRAME_US)
    ) u_timer (
        .CLK         (CLK),
        .RST         (RST),
        .us_cnt      (us_cnt_s),
        .pre_zero    (pre_zero_s),
        .frame_hit   (frame_hit_s),
        .frame_start (frame_start)
    );

    assign update_hit_s = pre_zero_s && (us_cnt_s == US_CNT_W'(UPDATE_US));
    assign en_now_s     = frame_hit_s ? enable : en_frame_r;

    // Sweep sequencing: four UPDATE cycles, one channel each.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (update_hit_s) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (sweep_r == 2'd3) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_UPDATE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Slew step for the channel selected by the sweep index.
    always_comb begin
        tgt_s  = target_r[sweep_r];
        cur_s  = current_r[sweep_r];
        diff_s = $signed({1'b0, tgt_s}) - $signed({1'b0, cur_s});
        if (int'(diff_s) > STEP_LIM) begin
            raw_s = cur_s + STEP_U;
        end else if (int'(diff_s) < -STEP_LIM) begin
            raw_s = cur_s - STEP_U;
        end else begin
            raw_s = tgt_s;
        end
        cur_nxt_s = clamp_us(raw_s);
    end

    // Next PWM levels from the in-frame microsecond position.
    always_comb begin
        pwm_nxt_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (en_now_s && (CMP_W'(us_cnt_s) < CMP_W'(current_r[i]))) begin
                pwm_nxt_s[i] = 1'b1;
            end else begin
                pwm_nxt_s[i] = 1'b0;
            end
        end
    end

    // Target capture on accepted writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target_r[i] <= CENTER_US;
            end
        end else if (wr_valid && wr_ready) begin
            target_r[wr_ch] <= clamp_us(wr_us);
        end
    end

    // Current widths move only during the sweep, well after every pulse has ended.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                current_r[i] <= CENTER_US;
            end
        end else if (state_r == ST_UPDATE) begin
            current_r[sweep_r] <= cur_nxt_s;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            sweep_r    <= 2'd0;
            en_frame_r <= 1'b0;
            wr_ready   <= 1'b0;
            busy       <= 1'b0;
            servo_pwm  <= 4'b0000;
        end else begin
            state_r    <= state_nxt_s;
            sweep_r    <= (state_r == ST_UPDATE) ? (sweep_r + 2'd1) : 2'd0;
            en_frame_r <= en_now_s;
            wr_ready   <= (state_nxt_s == ST_IDLE);
            busy       <= (state_nxt_s == ST_UPDATE);
            servo_pwm  <= pwm_nxt_s;
        end
    end

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// Scoreboard bench for servo_slew_scheduler: per-frame pulse widths, frame
// period, sweep/handshake timing and reset behaviour against a small model.
module tb_servo_slew_scheduler;

    localparam int CYC       = 2;
    localparam int FRAME     = 3000;
    localparam int UPD       = 2700;
    localparam int STEP      = 20;
    localparam int FRAME_CYC = FRAME * CYC;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_ch;
    logic [11:0] wr_us;
    logic [3:0]  servo_pwm;
    logic        frame_start;
    logic        busy;

    int n_vec;
    int n_err;
    int exp_q[$];
    int m_tgt[4];
    int m_cur[4];
    bit m_en;

    servo_slew_scheduler #(
        .CYC_PER_US (CYC),
        .FRAME_US   (FRAME),
        .UPDATE_US  (UPD),
        .STEP_US    (STEP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_us       (wr_us),
        .servo_pwm   (servo_pwm),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampm(input int v);
        if (v < 500) return 500;
        if (v > 2500) return 2500;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = 1500;
            m_cur[i] = 1500;
        end
    endfunction

    function automatic void model_sweep();
        for (int i = 0; i < 4; i++) begin
`ifdef SERVO_SLEW_EN
            if (m_tgt[i] - m_cur[i] > STEP) m_cur[i] = m_cur[i] + STEP;
            else if (m_tgt[i] - m_cur[i] < -STEP) m_cur[i] = m_cur[i] - STEP;
            else m_cur[i] = m_tgt[i];
`else
            m_cur[i] = m_tgt[i];
`endif
        end
    endfunction

    // Starts on a sampled frame_start cycle, ends on the next one.
    // mode 0: no write, 1: write at frame start, 2: write raised at sweep start.
    task automatic run_frame(input int mode, input int ch, input int us, input string tag);
        int  hi[4];
        int  nb, nr, n, acc, last_busy;
        bit  take;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        nb = 0; nr = 0; n = 0; acc = -1; last_busy = -1;
        if (mode == 1) begin
            wr_ch = 2'(ch); wr_us = 12'(us); wr_valid = 1'b1;
        end
        do begin
            if (mode == 2 && busy && !wr_valid && acc < 0) begin
                wr_ch = 2'(ch); wr_us = 12'(us); wr_valid = 1'b1;
            end
            for (int i = 0; i < 4; i++) if (servo_pwm[i]) hi[i]++;
            if (busy) begin nb++; last_busy = n; end
            if (!wr_ready) nr++;
            take = wr_valid && wr_ready;
            @(posedge CLK); #1;
            if (take) begin wr_valid = 1'b0; acc = n; end
            n++;
        end while (!frame_start && n < FRAME_CYC + 16);
        check_eq({tag, "_period"}, n, FRAME_CYC);
        check_eq({tag, "_busy"}, nb, 4);
        check_eq({tag, "_notready"}, nr, 4);
        if (mode == 1) check_eq({tag, "_acc"}, acc, 0);
        if (mode == 2) check_eq({tag, "_acc"}, acc, last_busy + 1);
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) check_eq($sformatf("%s_sb_empty%0d", tag, i), 0, 1);
            else check_eq($sformatf("%s_w%0d", tag, i), hi[i], exp_q.pop_front());
        end
    endtask

    task automatic do_frame(input int mode, input int ch, input int us, input bit new_en, input string tag);
        for (int i = 0; i < 4; i++) exp_q.push_back(m_en ? m_cur[i] * CYC : 0);
        enable = new_en;
        run_frame(mode, ch, us, tag);
        if (mode == 1) m_tgt[ch] = clampm(us);
        model_sweep();
        if (mode == 2) m_tgt[ch] = clampm(us);
        m_en = new_en;
    endtask

    task automatic reset_in_sweep();
        int n;
        n = 0;
        while (!busy && n < FRAME_CYC) begin
            @(posedge CLK); #1;
            n++;
        end
        check_eq("rst_sweep_seen", busy, 1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_eq("rst_sweep2_busy", busy, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_eq("rst_pwm", servo_pwm, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", wr_ready, 0);
        check_eq("rst_fs", frame_start, 0);
        RST = 1'b0;
        model_reset();
        m_en = enable;
        @(posedge CLK); #1;
        check_eq("rst2_fs", frame_start, 1);
        check_eq("rst2_ready", wr_ready, 1);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        RST = 1'b1; enable = 1'b1; wr_valid = 1'b0; wr_ch = 2'd0; wr_us = 12'd0;
        model_reset();
        m_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("init_pwm", servo_pwm, 0);
        check_eq("init_fs", frame_start, 0);
        check_eq("init_busy", busy, 0);
        check_eq("init_ready", wr_ready, 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        check_eq("first_ready", wr_ready, 1);
        check_eq("first_fs", frame_start, 1);

        do_frame(1, 0, 1600, 1'b1, "f0");
        do_frame(1, 1, 100,  1'b1, "f1");
        do_frame(2, 2, 1510, 1'b1, "f2");
        do_frame(1, 3, 4095, 1'b0, "f3");
        do_frame(1, 1, 3000, 1'b1, "f4");
        do_frame(1, 2, 0,    1'b1, "f5");
        do_frame(0, 0, 0,    1'b1, "f6");
        reset_in_sweep();
        do_frame(0, 0, 0,    1'b1, "f7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
